rcc_dom_rst_seq: RTL and testbench
==================================

RCC_DOM_RST_SEQ -- requirements
Module: rcc_dom_rst_seq

Interface
REQ-001 SHALL have parameter RST_DURATION, default 10: number of clk edges dom_rst_n is held low; legal range 1..255.
REQ-002 SHALL have parameter CLK_ON_DELAY, default 8: number of clk edges from dom_rst_n release to dom_clk_en assertion; legal range 1..255.
REQ-003 SHALL have parameter CNT_W, default 8: counter width; must satisfy 2^CNT_W > max(RST_DURATION, CLK_ON_DELAY).
REQ-004 SHALL have port clk, input, 1: single sequencer clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port rst_req, input, 1: domain reset request, level, already synchronous to clk.
REQ-007 SHALL have port pwr_ok, input, 1: domain power good, level, already synchronous to clk.
REQ-008 SHALL have port dom_rst_n, output, 1: domain reset, active-low, registered.
REQ-009 SHALL have port dom_clk_en, output, 1: domain clock-gate enable, registered.
REQ-010 SHALL have port seq_busy, output, 1: high whenever the state is not RUN.
REQ-011 SHALL have port seq_done, output, 1: single-cycle pulse on entry to RUN, registered.
REQ-012 SHALL have port seq_state, output, 2: current state encoding.

Function
REQ-013 SHALL implement four states with fixed encoding: ASSERT=0, WAIT_PWR=1, RELEASE=2, RUN=3.
REQ-014 SHALL drive outputs per state: ASSERT and WAIT_PWR give dom_rst_n=0 and dom_clk_en=0; RELEASE gives dom_rst_n=1 and dom_clk_en=0; RUN gives dom_rst_n=1 and dom_clk_en=1.
REQ-015 SHALL, with all outputs registered, change outputs on the same edge as the state transition, with no combinational path from inputs to outputs.
REQ-016 SHALL, in ASSERT with rst_req=1, hold the counter at 0.
REQ-017 SHALL, in ASSERT with rst_req=0, increment the counter each edge; at the edge where cnt==RST_DURATION-1 it goes to RELEASE if pwr_ok=1, else to WAIT_PWR.
REQ-018 SHALL, in ASSERT, ignore pwr_ok except at the exit edge.
REQ-019 SHALL, in WAIT_PWR, go to RELEASE on the first edge that samples pwr_ok=1 and rst_req=0; rst_req=1 goes to ASSERT with cnt=0.
REQ-020 SHALL, in RELEASE, increment the counter each edge and go to RUN at the edge where cnt==CLK_ON_DELAY-1.
REQ-021 SHALL, in RELEASE or RUN, go to ASSERT with cnt=0 on an edge sampling rst_req=1 or pwr_ok=0; clock and reset drop on the same edge.
REQ-022 SHALL, when rst_req=1 and pwr_ok=0 are sampled simultaneously, treat it as one event, going to ASSERT with cnt=0.
REQ-023 SHALL clear the counter to 0 on every state change.
REQ-024 SHALL assert seq_done for exactly one cycle, coincident with the first cycle of dom_clk_en=1.

Reset
REQ-025 SHALL, while rst=1, asynchronously force state=ASSERT, cnt=0, dom_rst_n=0, dom_clk_en=0, seq_done=0, seq_busy=1, seq_state=0.
REQ-026 SHALL, after rst deasserts, start the power-on sequence automatically with no request needed; the first clk edge with rst=0 counts as edge 1.
REQ-027 SHALL, if rst asserts mid-sequence in any state, abort immediately and restart from REQ-025 values.

Verification
REQ-028 SHALL cover power-on with defaults, pwr_ok=1, rst_req=0 -> dom_rst_n rises after edge 10; dom_clk_en and a seq_done pulse after edge 18; seq_state=3.
REQ-029 SHALL cover rst_req high for 5 cycles during RUN -> both outputs drop at the first sampling edge; dom_rst_n rises 10 edges after the last edge sampling rst_req=1; dom_clk_en follows 8 edges later.
REQ-030 SHALL cover pwr_ok=0 through power-on -> sequence holds in WAIT_PWR (seq_state=1, dom_rst_n=0) indefinitely; pwr_ok rising -> RELEASE next edge, RUN 8 edges later.
REQ-031 SHALL cover pwr_ok dropping at RELEASE cnt=4 -> ASSERT next edge with dom_rst_n=0 and no seq_done; the full 10+8 sequence reruns.
REQ-032 SHALL cover rst asserted asynchronously mid-RELEASE, between clk edges -> outputs take REQ-025 values with no clk edge; sequence restarts at edge 1 after release.
REQ-033 SHALL cover RST_DURATION=1, CLK_ON_DELAY=1 -> dom_rst_n rises after edge 1; dom_clk_en and seq_done after edge 2.

Source files
------------

// File: rtl/rcc_dom_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : rcc_dom_rst_seq
// Brief    : Power-domain reset / clock-enable sequencer with registered outputs
// Revision : 1.0 - initial release
// ============================================================================
module rcc_dom_rst_seq #(
    parameter int unsigned RST_DURATION = 10,
    parameter int unsigned CLK_ON_DELAY = 8,
    parameter int unsigned CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rst_req,
    input  logic       pwr_ok,
    output logic       dom_rst_n,
    output logic       dom_clk_en,
    output logic       seq_busy,
    output logic       seq_done,
    output logic [1:0] seq_state
);

    localparam logic [1:0] c_ST_ASSERT   = 2'd0;
    localparam logic [1:0] c_ST_WAIT_PWR = 2'd1;
    localparam logic [1:0] c_ST_RELEASE  = 2'd2;
    localparam logic [1:0] c_ST_RUN      = 2'd3;

    localparam logic [CNT_W-1:0] c_RST_LAST = CNT_W'(RST_DURATION - 1);
    localparam logic [CNT_W-1:0] c_CLK_LAST = CNT_W'(CLK_ON_DELAY - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dom_rst_n;
    logic             r_dom_clk_en;
    logic             r_seq_done;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_abort;

    // Any loss of power or a reset request in the live states collapses the domain at once.
    assign w_abort = rst_req | ~pwr_ok;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_ST_ASSERT: begin
                if (rst_req) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == c_RST_LAST) begin
                    w_state_nxt = pwr_ok ? c_ST_RELEASE : c_ST_WAIT_PWR;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            c_ST_WAIT_PWR: begin
                w_cnt_nxt = '0;
                if (rst_req) begin
                    w_state_nxt = c_ST_ASSERT;
                end else if (pwr_ok) begin
                    w_state_nxt = c_ST_RELEASE;
                end
            end
            c_ST_RELEASE: begin
                if (w_abort) begin
                    w_state_nxt = c_ST_ASSERT;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_CLK_LAST) begin
                    w_state_nxt = c_ST_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_cnt_nxt = '0;
                if (w_abort) begin
                    w_state_nxt = c_ST_ASSERT;
                end
            end
        endcase
    end

    // Outputs are decoded from the next state so they flip on the same edge as the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_ASSERT;
            r_cnt        <= '0;
            r_dom_rst_n  <= 1'b0;
            r_dom_clk_en <= 1'b0;
            r_seq_done   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_dom_rst_n  <= (w_state_nxt == c_ST_RELEASE) || (w_state_nxt == c_ST_RUN);
            r_dom_clk_en <= (w_state_nxt == c_ST_RUN);
            r_seq_done   <= (w_state_nxt == c_ST_RUN) && (r_state != c_ST_RUN);
        end
    end

    assign dom_rst_n  = r_dom_rst_n;
    assign dom_clk_en = r_dom_clk_en;
    assign seq_done   = r_seq_done;
    assign seq_state  = r_state;
    assign seq_busy   = (r_state != c_ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_rcc_dom_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_rcc_dom_rst_seq
// Brief    : Directed self-checking bench for rcc_dom_rst_seq
// Revision : 1.0 - initial release
// ============================================================================
module tb_rcc_dom_rst_seq;

    logic       clk;
    logic       rst;
    logic       rst_req;
    logic       pwr_ok;
    logic       dom_rst_n,  dom_clk_en,  seq_busy,  seq_done;
    logic [1:0] seq_state;
    logic       s_dom_rst_n, s_dom_clk_en, s_seq_busy, s_seq_done;
    logic [1:0] s_seq_state;

    int checks   = 0;
    int failures = 0;

    rcc_dom_rst_seq u_dut (
        .clk        (clk),
        .rst        (rst),
        .rst_req    (rst_req),
        .pwr_ok     (pwr_ok),
        .dom_rst_n  (dom_rst_n),
        .dom_clk_en (dom_clk_en),
        .seq_busy   (seq_busy),
        .seq_done   (seq_done),
        .seq_state  (seq_state)
    );

    rcc_dom_rst_seq #(.RST_DURATION(1), .CLK_ON_DELAY(1), .CNT_W(8)) u_dut_min (
        .clk        (clk),
        .rst        (rst),
        .rst_req    (1'b0),
        .pwr_ok     (1'b1),
        .dom_rst_n  (s_dom_rst_n),
        .dom_clk_en (s_dom_clk_en),
        .seq_busy   (s_seq_busy),
        .seq_done   (s_seq_done),
        .seq_state  (s_seq_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // {rst_n, clk_en, done, busy, state}
    function automatic int pk(input logic a, input logic b, input logic c,
                              input logic d, input logic [1:0] s);
        return int'({a, b, c, d, s});
    endfunction

    task automatic chk_main(input string tag, input int exp);
        chk(tag, pk(dom_rst_n, dom_clk_en, seq_done, seq_busy, seq_state), exp);
    endtask

    task automatic chk_min(input string tag, input int exp);
        chk(tag, pk(s_dom_rst_n, s_dom_clk_en, s_seq_done, s_seq_busy, s_seq_state), exp);
    endtask

    localparam int E_ASSERT  = 6'b0001_00;
    localparam int E_WAIT    = 6'b0001_01;
    localparam int E_RELEASE = 6'b1001_10;
    localparam int E_RUN_1ST = 6'b1110_11;
    localparam int E_RUN     = 6'b1100_11;

    initial begin
        rst     = 1'b1;
        rst_req = 1'b0;
        pwr_ok  = 1'b1;
        tick(3);
        chk_main("reset_main", E_ASSERT);
        chk_min ("reset_min",  E_ASSERT);

        // Power-on with defaults; the minimal-timing instance runs alongside.
        rst = 1'b0;
        tick(1);
        chk_main("por_e1_main", E_ASSERT);
        chk_min ("min_e1", E_RELEASE);
        tick(1);
        chk_min ("min_e2", E_RUN_1ST);
        tick(1);
        chk_min ("min_e3", E_RUN);
        tick(6);
        chk_main("por_e9", E_ASSERT);
        tick(1);
        chk_main("por_e10", E_RELEASE);
        tick(7);
        chk_main("por_e17", E_RELEASE);
        tick(1);
        chk_main("por_e18", E_RUN_1ST);
        tick(1);
        chk_main("por_e19", E_RUN);

        // rst_req held for 5 edges during RUN.
        rst_req = 1'b1;
        tick(1);
        chk_main("req_drop", E_ASSERT);
        tick(4);
        chk_main("req_hold", E_ASSERT);
        rst_req = 1'b0;
        tick(9);
        chk_main("req_e9", E_ASSERT);
        tick(1);
        chk_main("req_e10", E_RELEASE);
        tick(7);
        chk_main("req_rel7", E_RELEASE);
        tick(1);
        chk_main("req_run", E_RUN_1ST);

        // pwr_ok drop in RELEASE at cnt=4.
        rst_req = 1'b1;
        tick(1);
        rst_req = 1'b0;
        tick(10);
        chk_main("pdrop_rel", E_RELEASE);
        tick(4);
        pwr_ok = 1'b0;
        tick(1);
        chk_main("pdrop_assert", E_ASSERT);
        pwr_ok = 1'b1;
        tick(9);
        chk_main("pdrop_e9", E_ASSERT);
        tick(1);
        chk_main("pdrop_e10", E_RELEASE);
        tick(8);
        chk_main("pdrop_run", E_RUN_1ST);

        // pwr_ok low through the whole assert phase parks in WAIT_PWR.
        pwr_ok = 1'b0;
        tick(1);
        chk_main("wp_assert", E_ASSERT);
        tick(10);
        chk_main("wp_enter", E_WAIT);
        tick(20);
        chk_main("wp_hold", E_WAIT);
        pwr_ok = 1'b1;
        tick(1);
        chk_main("wp_release", E_RELEASE);
        tick(7);
        chk_main("wp_rel7", E_RELEASE);
        tick(1);
        chk_main("wp_run", E_RUN_1ST);

        // Asynchronous rst in the middle of RELEASE, away from any edge.
        rst_req = 1'b1;
        tick(1);
        rst_req = 1'b0;
        tick(12);
        chk_main("ar_pre", E_RELEASE);
        #2;
        rst = 1'b1;
        #1;
        chk_main("ar_async_main", E_ASSERT);
        chk_min ("ar_async_min",  E_ASSERT);
        tick(1);
        rst = 1'b0;
        tick(9);
        chk_main("ar_e9", E_ASSERT);
        tick(1);
        chk_main("ar_e10", E_RELEASE);
        tick(8);
        chk_main("ar_run", E_RUN_1ST);

        // Simultaneous rst_req=1 and pwr_ok=0 is a single abort.
        rst_req = 1'b1;
        pwr_ok  = 1'b0;
        tick(1);
        chk_main("both_assert", E_ASSERT);
        rst_req = 1'b0;
        pwr_ok  = 1'b1;
        tick(10);
        chk_main("both_e10", E_RELEASE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
